// File: rtl/tx_arbiter.sv
// tx_arbiter: shares one serial TX channel between the scheduler (sc) and the
// instruction prefetcher (pf). It grants one command at a time, steers the
// payload handshake to the current owner, and keeps an in-order FIFO of reply
// owners so that RX data can be routed back to the unit that asked for it.
//
// Ports
//   clk, rst_n                         clock, async active-low reset
//   sc_reserve                         scheduler holds off new prefetch grants
//   sc_cmd_valid/sc_cmd/sc_reply_wanted scheduler command request
//   sc_data                            scheduler payload
//   sc_started/sc_data_next/sc_done    scheduler handshake outputs
//   pf_*                               same set for the prefetcher (no reserve)
//   tx_command_valid/tx_command        command offered to the serializer
//   tx_command_started                 serializer accepted the command
//   tx_data/tx_data_next/tx_done       payload path and completion from serializer
//   rx_done                            one reply fully received (pops owner FIFO)
//   rx_owner_valid/rx_owner_pf         head of reply-owner FIFO (1 = prefetch)
module tx_arbiter #(
  parameter int unsigned CMD_BITS    = 4,
  parameter int unsigned NSHIFT      = 2,
  parameter int unsigned OUTSTANDING = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                sc_reserve,
  input  logic                sc_cmd_valid,
  input  logic [CMD_BITS-1:0] sc_cmd,
  input  logic                sc_reply_wanted,
  input  logic [NSHIFT-1:0]   sc_data,
  output logic                sc_started,
  output logic                sc_data_next,
  output logic                sc_done,
  input  logic                pf_cmd_valid,
  input  logic [CMD_BITS-1:0] pf_cmd,
  input  logic                pf_reply_wanted,
  input  logic [NSHIFT-1:0]   pf_data,
  output logic                pf_started,
  output logic                pf_data_next,
  output logic                pf_done,
  output logic                tx_command_valid,
  output logic [CMD_BITS-1:0] tx_command,
  input  logic                tx_command_started,
  output logic [NSHIFT-1:0]   tx_data,
  input  logic                tx_data_next,
  input  logic                tx_done,
  input  logic                rx_done,
  output logic                rx_owner_valid,
  output logic                rx_owner_pf
);

  localparam int unsigned CNT_W = $clog2(OUTSTANDING + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_SC = 2'd1,
    BUSY_PF = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic                   last_pf_q, last_pf_d;
  logic [OUTSTANDING-1:0] fifo_q, fifo_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;

  // Arbitration intermediates
  logic fifo_full;
  logic sc_elig, pf_elig;
  logic sel_pf;
  logic grant;
  logic push, pop;
  logic [CNT_W-1:0] cnt_mid;

  // State, round-robin pointer and reply-owner FIFO registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      last_pf_q <= 1'b0;
      fifo_q    <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      last_pf_q <= last_pf_d;
      fifo_q    <= fifo_d;
      cnt_q     <= cnt_d;
    end
  end

  // Next-state and handshake steering
  always_comb begin
    state_d          = state_q;
    last_pf_d        = last_pf_q;
    sc_started       = 1'b0;
    sc_data_next     = 1'b0;
    sc_done          = 1'b0;
    pf_started       = 1'b0;
    pf_data_next     = 1'b0;
    pf_done          = 1'b0;
    tx_command_valid = 1'b0;
    tx_command       = '0;
    tx_data          = '0;
    grant            = 1'b0;
    push             = 1'b0;

    fifo_full = (cnt_q == CNT_W'(OUTSTANDING));
    // rst_n gating keeps the command offer at zero while reset is asserted,
    // even though it is otherwise a pure function of the request inputs.
    sc_elig = rst_n && (state_q == IDLE) && sc_cmd_valid &&
              (!sc_reply_wanted || !fifo_full);
    pf_elig = rst_n && (state_q == IDLE) && pf_cmd_valid && !sc_reserve &&
              (!pf_reply_wanted || !fifo_full);
    // With both eligible sc_reserve is necessarily low, so plain round-robin applies.
    sel_pf = pf_elig && (!sc_elig || !last_pf_q);

    unique case (state_q)
      IDLE: begin
        tx_command_valid = sc_elig || pf_elig;
        if (sel_pf)       tx_command = pf_cmd;
        else if (sc_elig) tx_command = sc_cmd;
        grant = tx_command_valid && tx_command_started;
        if (grant) begin
          sc_started = !sel_pf;
          pf_started = sel_pf;
          last_pf_d  = sel_pf;
          state_d    = sel_pf ? BUSY_PF : BUSY_SC;
          push       = sel_pf ? pf_reply_wanted : sc_reply_wanted;
        end
      end
      BUSY_SC: begin
        tx_data      = sc_data;
        sc_data_next = tx_data_next;
        sc_done      = tx_done;
        if (tx_done) state_d = IDLE;
      end
      BUSY_PF: begin
        tx_data      = pf_data;
        pf_data_next = tx_data_next;
        pf_done      = tx_done;
        if (tx_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Reply-owner FIFO: head at bit 0, pop shifts down, push writes at the tail
  always_comb begin
    fifo_d  = fifo_q;
    pop     = rx_done && (cnt_q != '0);
    cnt_mid = cnt_q;
    if (pop) begin
      fifo_d  = fifo_q >> 1;
      cnt_mid = cnt_q - CNT_W'(1);
    end
    cnt_d = cnt_mid;
    if (push) begin
      for (int unsigned i = 0; i < OUTSTANDING; i++) begin
        if (cnt_mid == CNT_W'(i)) fifo_d[i] = sel_pf;
      end
      cnt_d = cnt_mid + CNT_W'(1);
    end
    rx_owner_valid = (cnt_q != '0);
    rx_owner_pf    = fifo_q[0];
  end

endmodule

// File: tb/tb_tx_arbiter.sv
// Randomized scoreboard bench for tx_arbiter. Each cycle the stimulus process
// drives inputs, predicts the outputs from a transaction-level model (owner,
// round-robin flag, queue of reply owners) and queues the prediction; the
// monitor pops and compares against the DUT.
module tb_tx_arbiter;
  localparam int unsigned CB   = 4;
  localparam int unsigned NS   = 2;
  localparam int unsigned OUTS = 2;
  localparam int unsigned NCYC = 4000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          sc_reserve, sc_cmd_valid, sc_reply_wanted;
  logic [CB-1:0] sc_cmd;
  logic [NS-1:0] sc_data;
  logic          sc_started, sc_data_next, sc_done;
  logic          pf_cmd_valid, pf_reply_wanted;
  logic [CB-1:0] pf_cmd;
  logic [NS-1:0] pf_data;
  logic          pf_started, pf_data_next, pf_done;
  logic          tx_command_valid, tx_command_started;
  logic [CB-1:0] tx_command;
  logic [NS-1:0] tx_data;
  logic          tx_data_next, tx_done, rx_done;
  logic          rx_owner_valid, rx_owner_pf;

  tx_arbiter #(.CMD_BITS(CB), .NSHIFT(NS), .OUTSTANDING(OUTS)) dut (
    .clk(clk), .rst_n(rst_n),
    .sc_reserve(sc_reserve), .sc_cmd_valid(sc_cmd_valid), .sc_cmd(sc_cmd),
    .sc_reply_wanted(sc_reply_wanted), .sc_data(sc_data),
    .sc_started(sc_started), .sc_data_next(sc_data_next), .sc_done(sc_done),
    .pf_cmd_valid(pf_cmd_valid), .pf_cmd(pf_cmd), .pf_reply_wanted(pf_reply_wanted),
    .pf_data(pf_data), .pf_started(pf_started), .pf_data_next(pf_data_next),
    .pf_done(pf_done), .tx_command_valid(tx_command_valid), .tx_command(tx_command),
    .tx_command_started(tx_command_started), .tx_data(tx_data),
    .tx_data_next(tx_data_next), .tx_done(tx_done), .rx_done(rx_done),
    .rx_owner_valid(rx_owner_valid), .rx_owner_pf(rx_owner_pf)
  );

  typedef struct packed {
    logic          sc_started, sc_data_next, sc_done;
    logic          pf_started, pf_data_next, pf_done;
    logic          tx_command_valid;
    logic [CB-1:0] tx_command;
    logic [NS-1:0] tx_data;
    logic          rx_owner_valid, rx_owner_pf;
  } exp_t;

  exp_t exp_q[$];
  event vec_ev;
  int   n_vec = 0;
  int   n_err = 0;

  // Model state: owner 0 = none, 1 = scheduler, 2 = prefetch
  int owner   = 0;
  bit last_pf = 1'b0;
  bit rq[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s vec=%0d got=%0h want=%0h", name, n_vec, act, exp_v);
    end
  endtask

  // Monitor: compares the DUT against the oldest pending prediction
  initial begin
    exp_t e;
    forever begin
      @(vec_ev);
      #1;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL scoreboard_empty vec=%0d got=0 want=1", n_vec);
      end else begin
        e = exp_q.pop_front();
        n_vec++;
        check("sc_started",       32'(sc_started),       32'(e.sc_started));
        check("sc_data_next",     32'(sc_data_next),     32'(e.sc_data_next));
        check("sc_done",          32'(sc_done),          32'(e.sc_done));
        check("pf_started",       32'(pf_started),       32'(e.pf_started));
        check("pf_data_next",     32'(pf_data_next),     32'(e.pf_data_next));
        check("pf_done",          32'(pf_done),          32'(e.pf_done));
        check("tx_command_valid", 32'(tx_command_valid), 32'(e.tx_command_valid));
        check("tx_command",       32'(tx_command),       32'(e.tx_command));
        check("tx_data",          32'(tx_data),          32'(e.tx_data));
        check("rx_owner_valid",   32'(rx_owner_valid),   32'(e.rx_owner_valid));
        check("rx_owner_pf",      32'(rx_owner_pf),      32'(e.rx_owner_pf));
      end
    end
  end

  // Stimulus and reference model
  initial begin
    exp_t e;
    bit   sc_ok, pf_ok, pick_pf, any, sc_was_started, pf_was_started, rw;
    rst_n = 1'b0;
    sc_reserve = 0; sc_cmd_valid = 0; sc_cmd = '0; sc_reply_wanted = 0; sc_data = '0;
    pf_cmd_valid = 0; pf_cmd = '0; pf_reply_wanted = 0; pf_data = '0;
    tx_command_started = 0; tx_data_next = 0; tx_done = 0; rx_done = 0;
    sc_was_started = 0; pf_was_started = 0;

    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(negedge clk);
      // Resets are more frequent while the scheduler owns the channel
      if (cyc < 3) rst_n = 1'b0;
      else if (owner == 1) rst_n = ($urandom_range(0, 39) != 0);
      else rst_n = ($urandom_range(0, 299) != 0);

      if ($urandom_range(0, 5) == 0) sc_reserve = ~sc_reserve;

      // Requesters hold cmd/reply_wanted until started; they may also withdraw
      if (sc_was_started) sc_cmd_valid = 1'b0;
      if (!sc_cmd_valid) begin
        if ($urandom_range(0, 2) == 0) begin
          sc_cmd_valid    = 1'b1;
          sc_cmd          = CB'($urandom);
          sc_reply_wanted = ($urandom_range(0, 3) != 0);
        end
      end else if ($urandom_range(0, 9) == 0) sc_cmd_valid = 1'b0;

      if (pf_was_started) pf_cmd_valid = 1'b0;
      if (!pf_cmd_valid) begin
        if ($urandom_range(0, 2) == 0) begin
          pf_cmd_valid    = 1'b1;
          pf_cmd          = CB'($urandom);
          pf_reply_wanted = ($urandom_range(0, 2) == 0);
        end
      end else if ($urandom_range(0, 9) == 0) pf_cmd_valid = 1'b0;

      sc_data            = NS'($urandom);
      pf_data            = NS'($urandom);
      tx_command_started = ($urandom_range(0, 1) == 0);
      tx_data_next       = ($urandom_range(0, 1) == 0);
      tx_done            = ($urandom_range(0, 3) == 0);
      rx_done            = ($urandom_range(0, 7) == 0);

      // Prediction from the arbitration rules
      e = '0;
      sc_was_started = 0;
      pf_was_started = 0;
      if (!rst_n) begin
        owner   = 0;
        last_pf = 1'b0;
        rq.delete();
      end else begin
        e.rx_owner_valid = (rq.size() > 0);
        e.rx_owner_pf    = (rq.size() > 0) ? rq[0] : 1'b0;
        rw = 1'b0;
        if (owner == 0) begin
          sc_ok = sc_cmd_valid && (!sc_reply_wanted || rq.size() < OUTS);
          pf_ok = pf_cmd_valid && !sc_reserve && (!pf_reply_wanted || rq.size() < OUTS);
          any   = sc_ok || pf_ok;
          if (sc_ok && pf_ok) pick_pf = !last_pf;
          else                pick_pf = pf_ok;
          e.tx_command_valid = any;
          e.tx_command       = !any ? '0 : (pick_pf ? pf_cmd : sc_cmd);
          if (any && tx_command_started) begin
            e.sc_started   = !pick_pf;
            e.pf_started   = pick_pf;
            sc_was_started = !pick_pf;
            pf_was_started = pick_pf;
            rw             = pick_pf ? pf_reply_wanted : sc_reply_wanted;
          end
        end else begin
          e.tx_data = (owner == 1) ? sc_data : pf_data;
          if (owner == 1) begin
            e.sc_data_next = tx_data_next;
            e.sc_done      = tx_done;
          end else begin
            e.pf_data_next = tx_data_next;
            e.pf_done      = tx_done;
          end
        end
        // Advance the model: pop first, then append the new owner
        if (rx_done && rq.size() > 0) void'(rq.pop_front());
        if (rw) rq.push_back(pf_was_started);
        if (sc_was_started || pf_was_started) begin
          owner   = pf_was_started ? 2 : 1;
          last_pf = pf_was_started;
        end else if (owner != 0 && tx_done) owner = 0;
      end
      exp_q.push_back(e);
      ->vec_ev;
    end

    @(negedge clk);
    #2;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain got=%0d want=0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
